// File: rtl/ob_pkg.sv
// Command and response payloads exchanged between clients, the concentrator and the order book.
package ob_pkg;

  typedef enum logic [1:0] {
    OP_BUY    = 2'd0,
    OP_SELL   = 2'd1,
    OP_CANCEL = 2'd2,
    OP_MODIFY = 2'd3
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [15:0] uid;
    logic [15:0] price;
    logic [15:0] qty;
  } cmd_t;

  typedef struct packed {
    logic [15:0] uid;
    logic [1:0]  status;
    logic [15:0] qty;
  } rsp_t;

endpackage

// File: rtl/ob_cmd_mux.sv
// N-channel concentrator: per-channel command FIFOs, round-robin issue into ob,
// and an in-flight tag FIFO that steers in-order ob responses back to their channel.
module ob_cmd_mux
  import ob_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned INFLIGHT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] ch_cmd_vld_r,
  input  cmd_t [N_CH-1:0] ch_cmd_r,
  output logic [N_CH-1:0] ch_cmd_full_r,
  output logic [N_CH-1:0] ch_rsp_vld,
  output rsp_t            ch_rsp,
  input  logic [N_CH-1:0] ch_rsp_accept,
  output logic            ob_cmd_vld_r,
  output cmd_t            ob_cmd_r,
  input  logic            ob_cmd_full_r,
  input  logic            ob_rsp_vld,
  input  rsp_t            ob_rsp,
  output logic            ob_rsp_accept,
  output logic [N_CH-1:0] ovf_r,
  output logic            spur_r
);

  localparam int unsigned CW     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned IW     = (INFLIGHT > 1) ? $clog2(INFLIGHT) : 1;
  localparam int unsigned IDEPTH = 1 << IW;

  cmd_t            fifo_mem     [N_CH][DEPTH];
  logic [AW-1:0]   fifo_wr      [N_CH];
  logic [AW-1:0]   fifo_rd      [N_CH];
  logic [AW:0]     fifo_cnt     [N_CH];
  logic [AW:0]     fifo_cnt_nxt [N_CH];
  logic [N_CH-1:0] push;
  logic [N_CH-1:0] pop;
  logic [N_CH-1:0] nonempty;

  logic [CW-1:0]   rr_ptr;
  logic [CW-1:0]   grant;
  logic [CW:0]     scan;
  logic            found;
  logic            issue;

  logic [CW-1:0]   if_mem [IDEPTH];
  logic [IW-1:0]   if_wr;
  logic [IW-1:0]   if_rd;
  logic [IW:0]     if_cnt;
  logic            if_empty;
  logic            if_pop;
  logic [CW-1:0]   if_head;

  // Pushes are gated by the registered full, so a slot freed this cycle is not reusable yet.
  always_comb begin
    push     = '0;
    nonempty = '0;
    for (int i = 0; i < N_CH; i++) begin
      push[i]     = ch_cmd_vld_r[i] & ~ch_cmd_full_r[i];
      nonempty[i] = (fifo_cnt[i] != '0);
    end
  end

  always_comb begin
    fifo_cnt_nxt = '{default: '0};
    for (int i = 0; i < N_CH; i++) begin
      fifo_cnt_nxt[i] = fifo_cnt[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
    end
  end

  // Round-robin: first non-empty channel at or after rr_ptr; in-flight limit uses the registered count.
  always_comb begin
    grant = '0;
    found = 1'b0;
    scan  = '0;
    for (int k = 0; k < N_CH; k++) begin
      scan = {1'b0, rr_ptr} + (CW+1)'(k);
      if (scan >= (CW+1)'(N_CH)) begin
        scan = scan - (CW+1)'(N_CH);
      end
      if (!found && nonempty[CW'(scan)]) begin
        found = 1'b1;
        grant = CW'(scan);
      end
    end
    issue = found & ~ob_cmd_full_r & (if_cnt < (IW+1)'(INFLIGHT));
    pop   = issue ? (N_CH'(1) << grant) : '0;
  end

  assign if_empty = (if_cnt == '0);
  assign if_head  = if_mem[if_rd];

  // Responses with nothing in flight are swallowed so ob never stalls on them.
  always_comb begin
    ch_rsp_vld = '0;
    if (ob_rsp_vld && !if_empty) begin
      ch_rsp_vld[if_head] = 1'b1;
    end
    ch_rsp        = ob_rsp;
    ob_rsp_accept = if_empty ? ob_rsp_vld : ch_rsp_accept[if_head];
    if_pop        = ob_rsp_vld & ob_rsp_accept & ~if_empty;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        for (int d = 0; d < DEPTH; d++) begin
          fifo_mem[i][d] <= '0;
        end
        fifo_wr[i]  <= '0;
        fifo_rd[i]  <= '0;
        fifo_cnt[i] <= '0;
      end
      ch_cmd_full_r <= '0;
      ovf_r         <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (push[i]) begin
          fifo_mem[i][fifo_wr[i]] <= ch_cmd_r[i];
          fifo_wr[i]              <= fifo_wr[i] + AW'(1);
        end
        if (pop[i]) begin
          fifo_rd[i] <= fifo_rd[i] + AW'(1);
        end
        fifo_cnt[i]      <= fifo_cnt_nxt[i];
        ch_cmd_full_r[i] <= (fifo_cnt_nxt[i] == (AW+1)'(DEPTH));
        if (ch_cmd_vld_r[i] && ch_cmd_full_r[i]) begin
          ovf_r[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ob_cmd_vld_r <= 1'b0;
      ob_cmd_r     <= '0;
      rr_ptr       <= '0;
    end else begin
      ob_cmd_vld_r <= issue;
      if (issue) begin
        ob_cmd_r <= fifo_mem[grant][fifo_rd[grant]];
        rr_ptr   <= (grant == CW'(N_CH - 1)) ? '0 : grant + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < IDEPTH; d++) begin
        if_mem[d] <= '0;
      end
      if_wr  <= '0;
      if_rd  <= '0;
      if_cnt <= '0;
      spur_r <= 1'b0;
    end else begin
      if (issue) begin
        if_mem[if_wr] <= grant;
        if_wr         <= if_wr + IW'(1);
      end
      if (if_pop) begin
        if_rd <= if_rd + IW'(1);
      end
      if_cnt <= if_cnt + (IW+1)'(issue) - (IW+1)'(if_pop);
      if (ob_rsp_vld && if_empty) begin
        spur_r <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ob_cmd_mux.md
Name: ob_cmd_mux

Overview:
- N-channel ingress/egress concentrator in front of the order book (ob).
- Each channel has its own command FIFO. A round-robin arbiter issues one command per cycle into ob's single cmd/rsp port.
- An in-flight tag FIFO routes each in-order ob response back to the channel that issued the command.
- Successor to the single-client ob harness: channel count, queue depth and outstanding depth are all parametrised.

Parameters:
- N_CH, 4, number of client channels (>=2).
- DEPTH, 4, per-channel command FIFO entries (power of 2, >=2).
- INFLIGHT, 8, maximum commands issued to ob and awaiting response (power of 2).

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous, active-low reset; all flops cleared while low.
- ch_cmd_vld_r  in  N_CH  per-channel command valid.
- ch_cmd_r  in  N_CH x ob_pkg::cmd_t  per-channel command.
- ch_cmd_full_r  out  N_CH  registered per-channel full.
- ch_rsp_vld  out  N_CH  per-channel response valid.
- ch_rsp  out  ob_pkg::rsp_t  response payload, shared across channels and qualified by ch_rsp_vld.
- ch_rsp_accept  in  N_CH  per-channel response accept.
- ob_cmd_vld_r  out  1  registered command valid to ob.
- ob_cmd_r  out  ob_pkg::cmd_t  registered command to ob.
- ob_cmd_full_r  in  1  ob backpressure.
- ob_rsp_vld  in  1  ob response valid.
- ob_rsp  in  ob_pkg::rsp_t  ob response.
- ob_rsp_accept  out  1  accept to ob.
- ovf_r  out  N_CH  sticky: command pushed while ch_cmd_full_r was high.
- spur_r  out  1  sticky: ob response received with no in-flight entry.

Behaviour:
- Reset values:
  - All FIFOs empty.
  - ch_cmd_full_r=0, ob_cmd_vld_r=0, ob_cmd_r=0, ovf_r=0, spur_r=0.
  - Round-robin pointer=0.
  - ch_rsp_vld=0 (in-flight FIFO empty). ob_rsp_accept=0.
- Channel push:
  - ch_cmd_vld_r[i] writes ch_cmd_r[i] into FIFO i at the edge.
  - If ch_cmd_full_r[i]=1 the command is dropped, FIFO i is unchanged, and ovf_r[i] is set.
- ch_cmd_full_r[i] is registered: it equals (next occupancy == DEPTH) and is computed after that cycle's push and pop.
- Simultaneous push and pop on a full FIFO:
  - The pop frees a slot, but full was already 1, so the push is dropped (ovf).
  - The next cycle shows full=0.
- Issue condition, evaluated each cycle:
  - issue = some FIFO non-empty AND !ob_cmd_full_r AND in-flight count < INFLIGHT.
  - When issue holds, the arbiter picks the first non-empty channel at or after the pointer (mod N_CH).
  - That channel's FIFO is popped; ob_cmd_vld_r<=1, ob_cmd_r<=head; the channel id is pushed into the in-flight FIFO; pointer<=grant+1 mod N_CH.
  - Otherwise ob_cmd_vld_r<=0 and ob_cmd_r holds its value.
- Latency: a command pushed at edge t appears on ob_cmd_vld_r after edge t+1 at the earliest (one cycle in FIFO, then the output register).
- Throughput: one command per cycle sustained.
- ob_cmd_vld_r is a single-cycle pulse per command. ob samples it directly; the block does not re-hold it under full.
- The pointer advances only on a grant.
- Response routing (combinational):
  - h = in-flight head.
  - ch_rsp_vld[h] = ob_rsp_vld & !inflight_empty; all other bits are 0.
  - ch_rsp = ob_rsp.
  - ob_rsp_accept = ch_rsp_accept[h].
  - The in-flight FIFO pops on ob_rsp_vld & ob_rsp_accept.
- Spurious response (ob_rsp_vld with in-flight empty): ob_rsp_accept=1, the response is discarded, spur_r is set.
- In-flight push and pop in the same cycle: the count is unchanged. The INFLIGHT limit is checked against the registered count, with no same-cycle pop credit.
- Reset mid-operation: all queued and in-flight state is discarded immediately. No response is routed after rst is deasserted until new commands are issued.

Test Plan:
- Single channel: ch0 pushes Op_Buy uid=5 qty=10 at cycle 1 → ob_cmd_vld_r=1 with uid=5 in cycle 2. ob_rsp uid=5 in cycle 4 → ch_rsp_vld=4'b0001 and ob_rsp_accept follows ch_rsp_accept[0].
- Fairness: all 4 channels push one command each in the same cycle → issue order ch0, ch1, ch2, ch3 on consecutive cycles. A second round starting with ch1 and ch2 pending and pointer=0 → grants ch1 then ch2.
- Full/overflow, DEPTH=4, ob_cmd_full_r=1:
  - ch2 pushes 4 commands → ch_cmd_full_r[2]=1 after the 4th edge.
  - A 5th push sets ovf_r[2] and leaves the FIFO content unchanged.
  - Releasing full drains all 4 commands in order.
- In-flight limit: INFLIGHT=8, no responses returned → exactly 8 issues and then ob_cmd_vld_r stays 0. One accepted response → exactly one further issue.
- Response backpressure and spurious:
  - Response for ch3 with ch_rsp_accept[3]=0 for 3 cycles → held, with no in-flight pop.
  - ob_rsp_vld while in-flight is empty → ob_rsp_accept=1 and spur_r=1.
- Async reset: assert rst=0 mid-burst, between clock edges → ob_cmd_vld_r, ch_cmd_full_r and ch_rsp_vld go to 0 immediately. After release the pointer is 0 and the FIFOs are empty.
